// File: rtl/pipelined_subtractor_if.sv
// Operand/result handshake bundle for the pipelined subtractor.
// The master side drives operands and downstream ready; the slave side is the subtractor.
interface pipelined_subtractor_if #(
  parameter int SIZE = 16
);
  logic            in_valid;
  logic            in_ready;
  logic [SIZE-1:0] a;
  logic [SIZE-1:0] b;
  logic            bin;
  logic            out_valid;
  logic            out_ready;
  logic [SIZE-1:0] d;
  logic            bout;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, d, bout
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, d, bout
  );
endinterface

// File: rtl/pipelined_subtractor.sv
// Chunked pipelined subtractor: d = a - b - bin, computed as a + ~b + ~bin one CHUNK
// slice per stage, with the carry and the still-unresolved operand chunks riding along.
module pipelined_subtractor #(
  parameter int SIZE  = 16,
  parameter int CHUNK = 4
) (
  input logic                   clk,
  input logic                   rst,
  pipelined_subtractor_if.slave bus
);

  localparam int STAGES = SIZE / CHUNK;

  if (SIZE % CHUNK != 0 || STAGES < 1) begin : g_bad_cfg
    $error("pipelined_subtractor: SIZE must be a non-zero multiple of CHUNK");
  end

  logic en;

  function automatic logic [CHUNK:0] chunk_add(
    input logic [CHUNK-1:0] x,
    input logic [CHUNK-1:0] y,
    input logic             ci
  );
    return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
  endfunction

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int RW = (k + 1) * CHUNK;  // result bits resolved once this stage is loaded
    localparam int UW = SIZE - RW;        // operand bits still unresolved after this stage

    logic                vld_p;
    logic                cy_p;
    logic [RW-1:0]       res_p;
    logic [UW+CHUNK-1:0] src_a;
    logic [UW+CHUNK-1:0] src_nb;
    logic                src_cy;
    logic                src_vld;
    logic [CHUNK:0]      sum;

    if (k == 0) begin : g_head
      assign src_a   = bus.a;
      assign src_nb  = ~bus.b;
      assign src_cy  = ~bus.bin;
      assign src_vld = bus.in_valid;
    end else begin : g_link
      assign src_a   = g_stage[k-1].g_ops.a_p;
      assign src_nb  = g_stage[k-1].g_ops.nb_p;
      assign src_cy  = g_stage[k-1].cy_p;
      assign src_vld = g_stage[k-1].vld_p;
    end

    assign sum = chunk_add(src_a[CHUNK-1:0], src_nb[CHUNK-1:0], src_cy);

    // ---- stage k register boundary ----
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_p <= 1'b0;
      end else if (en) begin
        vld_p <= src_vld;
      end
    end

    always_ff @(posedge clk) begin
      if (en) begin
        cy_p <= sum[CHUNK];
      end
    end

    if (k == 0) begin : g_res_first
      always_ff @(posedge clk) begin
        if (en) begin
          res_p <= sum[CHUNK-1:0];
        end
      end
    end else begin : g_res_next
      always_ff @(posedge clk) begin
        if (en) begin
          res_p <= {sum[CHUNK-1:0], g_stage[k-1].res_p};
        end
      end
    end

    if (UW > 0) begin : g_ops
      logic [UW-1:0] a_p;
      logic [UW-1:0] nb_p;

      always_ff @(posedge clk) begin
        if (en) begin
          a_p  <= src_a[UW+CHUNK-1:CHUNK];
          nb_p <= src_nb[UW+CHUNK-1:CHUNK];
        end
      end
    end
  end

  // ---- output boundary: last stage presented directly ----
  // Results are masked by valid so d/bout read zero whenever nothing is presented,
  // which also keeps uninitialised data registers from leaking out.
  assign en            = ~bus.out_valid | bus.out_ready;
  assign bus.in_ready  = en;
  assign bus.out_valid = g_stage[STAGES-1].vld_p;
  assign bus.d         = g_stage[STAGES-1].vld_p ? g_stage[STAGES-1].res_p : '0;
  assign bus.bout      = g_stage[STAGES-1].vld_p & ~g_stage[STAGES-1].cy_p;

endmodule

// File: tb/tb_pipelined_subtractor.sv
// Self-checking bench for pipelined_subtractor: vector table plus hand sequences,
// with a scoreboard queue filled on input transfer and drained on output transfer.
module tb_pipelined_subtractor;

  localparam int SIZE = 16;

  typedef struct {
    logic            v;
    logic [SIZE-1:0] a;
    logic [SIZE-1:0] b;
    logic            bin;
    logic [SIZE-1:0] d;
    logic            bout;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  pipelined_subtractor_if #(.SIZE(SIZE)) bus ();

  pipelined_subtractor #(.SIZE(SIZE), .CHUNK(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int            errors = 0;
  int            checks = 0;
  int            n_out  = 0;
  logic [SIZE:0] exp_res;
  logic [SIZE:0] sb[$];
  vec_t          vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [SIZE:0] model(input logic [SIZE-1:0] ia, input logic [SIZE-1:0] ib,
                                          input logic ibin);
    logic [SIZE:0] t;
    t = {1'b0, ia} - {1'b0, ib} - {{SIZE{1'b0}}, ibin};
    return t;
  endfunction

  // Scoreboard: push on accept, pop and compare on drain
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        if (sb.size() == 0) begin
          chk("unexpected_output", 32'd1, 32'd0);
        end else begin
          logic [SIZE:0] e;
          e = sb.pop_front();
          chk("result", {15'd0, bus.bout, bus.d}, {15'd0, e});
        end
      end
      if (bus.in_valid && bus.in_ready) sb.push_back(exp_res);
    end
  end

  task automatic set_in(input logic v, input logic [SIZE-1:0] ia, input logic [SIZE-1:0] ib,
                        input logic ibin, input logic [SIZE:0] e);
    bus.in_valid = v;
    bus.a        = ia;
    bus.b        = ib;
    bus.bin      = ibin;
    exp_res      = e;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic lat_test(input string name, input logic [SIZE-1:0] ia, input logic [SIZE-1:0] ib,
                          input logic ibin, input logic [SIZE:0] e);
    set_in(1'b1, ia, ib, ibin, e);
    next_cycle();
    bus.in_valid = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk(name, {31'd0, bus.out_valid}, (j == 3) ? 32'd1 : 32'd0);
      next_cycle();
    end
  endtask

  // Apply vecs one per cycle and compare the out_valid pattern against the input pattern delayed by 4
  task automatic run_vecs(input string name);
    int          n;
    logic [31:0] act;
    logic [31:0] req;
    n   = vecs.size();
    act = '0;
    req = '0;
    for (int c = 0; c < n + 6; c++) begin
      if (c < n) set_in(vecs[c].v, vecs[c].a, vecs[c].b, vecs[c].bin, {vecs[c].bout, vecs[c].d});
      else bus.in_valid = 1'b0;
      @(negedge clk);
      act[c] = bus.out_valid;
      next_cycle();
    end
    for (int c = 4; c < n + 4; c++) req[c] = vecs[c-4].v;
    chk(name, act, req);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    logic [SIZE:0] held;
    logic [SIZE:0] r;
    int            idx;
    int            stall_left;
    int            got0;
    logic [31:0]   mask;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.bin       = 1'b0;
    bus.out_ready = 1'b1;
    exp_res       = '0;

    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    chk("rst_d",         {16'd0, bus.d},         32'd0);
    chk("rst_bout",      {31'd0, bus.bout},      32'd0);
    next_cycle();
    rst = 1'b0;
    next_cycle();

    // Single op: exact latency and one-cycle presentation
    lat_test("latency_300_45", 16'd300, 16'd45, 1'b0, {1'b0, 16'd255});

    // Table: test-plan stream first (no gaps), then boundary and random vectors
    vecs.delete();
    vecs.push_back('{1'b1, 16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0});
    vecs.push_back('{1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0});
    vecs.push_back('{1'b1, 16'h8000, 16'h7FFF, 1'b0, 16'h0001, 1'b0});
    vecs.push_back('{1'b1, 16'd25,   16'd14,   1'b0, 16'd11,   1'b0});
    vecs.push_back('{1'b1, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1});
    vecs.push_back('{1'b1, 16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b1});
    vecs.push_back('{1'b1, 16'h0010, 16'h0001, 1'b1, 16'h000E, 1'b0});
    vecs.push_back('{1'b1, 16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0});
    vecs.push_back('{1'b1, 16'h0F0F, 16'hF0F0, 1'b0, 16'h1E1F, 1'b1});
    for (int i = 0; i < 6; i++) begin
      vec_t t;
      t.v   = 1'b1;
      t.a   = 16'($urandom);
      t.b   = 16'($urandom);
      t.bin = 1'($urandom);
      r     = model(t.a, t.b, t.bin);
      t.d   = r[SIZE-1:0];
      t.bout = r[SIZE];
      vecs.push_back(t);
    end
    run_vecs("stream_valid_pattern");

    // Bubbles travel through unchanged
    vecs.delete();
    vecs.push_back('{1'b1, 16'd100, 16'd1,  1'b0, 16'd99,   1'b0});
    vecs.push_back('{1'b0, 16'd0,   16'd0,  1'b0, 16'd0,    1'b0});
    vecs.push_back('{1'b1, 16'd5,   16'd6,  1'b0, 16'hFFFF, 1'b1});
    vecs.push_back('{1'b0, 16'd0,   16'd0,  1'b0, 16'd0,    1'b0});
    run_vecs("bubble_pattern");

    // Backpressure: 6 ops, 5-cycle stall once output appears
    idx        = 0;
    stall_left = 5;
    got0       = n_out;
    held       = '0;
    for (int c = 0; c < 40 && (n_out - got0) < 6; c++) begin
      if (bus.out_valid && stall_left > 0) begin
        bus.out_ready = 1'b0;
        stall_left--;
      end else begin
        bus.out_ready = 1'b1;
      end
      if (idx < 6) set_in(1'b1, 16'(16'h0400 * idx + 7), 16'(16'h0123 * idx), idx[0],
                          model(16'(16'h0400 * idx + 7), 16'(16'h0123 * idx), idx[0]));
      else bus.in_valid = 1'b0;
      @(negedge clk);
      if (!bus.out_ready) begin
        if (stall_left == 4) held = {bus.bout, bus.d};
        chk("bp_hold",     {15'd0, bus.bout, bus.d}, {15'd0, held});
        chk("bp_in_ready", {31'd0, bus.in_ready},    32'd0);
      end
      if (bus.in_valid && bus.in_ready) idx++;
      next_cycle();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk("bp_stall_done", stall_left, 0);
    chk("bp_count",      n_out - got0, 6);
    chk("bp_sb_empty",   sb.size(), 0);

    // Reset with three items in flight
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 16'(16'h2000 + i), 16'd1, 1'b0, model(16'(16'h2000 + i), 16'd1, 1'b0));
      next_cycle();
    end
    bus.in_valid = 1'b0;
    next_cycle();
    chk("pre_rst_valid", {31'd0, bus.out_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("async_rst_d",     {16'd0, bus.d},         32'd0);
    chk("async_rst_bout",  {31'd0, bus.bout},      32'd0);
    sb.delete();
    next_cycle();
    next_cycle();
    rst  = 1'b0;
    mask = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      mask[c] = bus.out_valid;
      next_cycle();
    end
    chk("no_stale_after_rst", mask, 32'd0);
    lat_test("latency_after_rst", 16'hABCD, 16'h1111, 1'b1, {1'b0, 16'h9ABB});

    repeat (3) next_cycle();
    chk("final_sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
